// File: rtl/memory_stage.sv
// MEM stage: issues loads/stores to data memory and registers the MEM/WB bundle.
// Optional MEM_WAIT_STATE_EN: WAIT completes only on memAck (otherwise fixed one-cycle memory).
module memory_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] instruction_In,
    input  logic [19:0] aluResult_In,
    input  logic [19:0] dataRFOut1_In,
    input  logic [19:0] dataRFOut2_In,
    input  logic [3:0]  address_In,
    output logic        memReq,
    output logic        memWe,
    output logic [7:0]  memAddr,
    output logic [19:0] memWriteData,
    input  logic        memAck,
    input  logic [19:0] memReadData_In,
    output logic [19:0] instruction,
    output logic [19:0] dataRFOut1,
    output logic [19:0] dataRFOut2,
    output logic [19:0] aluRESULTout,
    output logic [19:0] memoryReadData,
    output logic [3:0]  address,
    output logic        out_valid
);

    localparam logic [0:0]  IDLE   = 1'b0;
    localparam logic [0:0]  WAIT   = 1'b1;
    localparam logic [19:0] BUBBLE = 20'hC0000;

    function automatic logic isStoreOp(input logic [3:0] op);
        return (op == 4'b1100);
    endfunction

    function automatic logic isLoadOp(input logic [3:0] op);
        return (op == 4'b1101) || (op == 4'b1111);
    endfunction

    logic [0:0]  state_r;
    logic [0:0]  stateNext_s;
    logic        acceptMem_s;
    logic        acceptAlu_s;
    logic        complete_s;
    logic        waitDone_s;
    logic        inIsMem_s;
    logic [19:0] latInstr_r;
    logic [19:0] latAlu_r;
    logic [19:0] latRf1_r;
    logic [19:0] latRf2_r;
    logic [3:0]  latAddr_r;

    assign inIsMem_s = isStoreOp(instruction_In[19:16]) || isLoadOp(instruction_In[19:16]);
    assign in_ready  = (state_r == IDLE) && !reset;

`ifdef MEM_WAIT_STATE_EN
    assign waitDone_s = memAck;
`else
    // Fixed single-cycle memory: the ack is deliberately not allowed to gate completion.
    assign waitDone_s = memAck | 1'b1;
`endif

    // Next-state and transfer decode
    always_comb begin
        stateNext_s = state_r;
        acceptMem_s = 1'b0;
        acceptAlu_s = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (inIsMem_s) begin
                        acceptMem_s = 1'b1;
                        stateNext_s = WAIT;
                    end else begin
                        acceptAlu_s = 1'b1;
                        stateNext_s = IDLE;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            WAIT: begin
                if (waitDone_s) begin
                    complete_s  = 1'b1;
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = WAIT;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Capture of the execute bundle for an in-flight memory operation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            latInstr_r <= 20'h00000;
            latAlu_r   <= 20'h00000;
            latRf1_r   <= 20'h00000;
            latRf2_r   <= 20'h00000;
            latAddr_r  <= 4'h0;
        end else if (acceptMem_s) begin
            latInstr_r <= instruction_In;
            latAlu_r   <= aluResult_In;
            latRf1_r   <= dataRFOut1_In;
            latRf2_r   <= dataRFOut2_In;
            latAddr_r  <= address_In;
        end
    end

    // Data-memory request port; address/data hold their last values when idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            memAddr      <= 8'h00;
            memWriteData <= 20'h00000;
        end else if (acceptMem_s) begin
            memReq       <= 1'b1;
            memWe        <= isStoreOp(instruction_In[19:16]);
            memAddr      <= aluResult_In[7:0];
            memWriteData <= dataRFOut2_In;
        end else if (complete_s) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
        end
    end

    // MEM/WB registers; a bubble instruction is presented whenever nothing retires
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction    <= BUBBLE;
            dataRFOut1     <= 20'h00000;
            dataRFOut2     <= 20'h00000;
            aluRESULTout   <= 20'h00000;
            memoryReadData <= 20'h00000;
            address        <= 4'h0;
            out_valid      <= 1'b0;
        end else if (acceptAlu_s) begin
            instruction    <= instruction_In;
            dataRFOut1     <= dataRFOut1_In;
            dataRFOut2     <= dataRFOut2_In;
            aluRESULTout   <= aluResult_In;
            memoryReadData <= 20'h00000;
            address        <= address_In;
            out_valid      <= 1'b1;
        end else if (complete_s) begin
            instruction    <= latInstr_r;
            dataRFOut1     <= latRf1_r;
            dataRFOut2     <= latRf2_r;
            aluRESULTout   <= latAlu_r;
            memoryReadData <= isLoadOp(latInstr_r[19:16]) ? memReadData_In : 20'h00000;
            address        <= latAddr_r;
            out_valid      <= 1'b1;
        end else begin
            instruction <= BUBBLE;
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_memory_stage;

    localparam logic [19:0] BUBBLE = 20'hC0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] instruction_In, aluResult_In, dataRFOut1_In, dataRFOut2_In;
    logic [3:0]  address_In;
    logic        memReq, memWe, memAck;
    logic [7:0]  memAddr;
    logic [19:0] memWriteData, memReadData_In;
    logic [19:0] instruction, dataRFOut1, dataRFOut2, aluRESULTout, memoryReadData;
    logic [3:0]  address;
    logic        out_valid;

    int passCount  = 0;
    int checkCount = 0;

    // Model: at most one memory op pending, plus the last retired bundle
    bit          busy;
    logic [19:0] bInstr, bAlu, bRf1, bRf2;
    logic [3:0]  bAddr;
    logic        expValid;
    logic [19:0] expInstr, expAlu, expRf1, expRf2, expMrd;
    logic [3:0]  expAddr;
    logic [7:0]  expMemAddr;
    logic [19:0] expMemWd;

    memory_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction_In(instruction_In), .aluResult_In(aluResult_In),
        .dataRFOut1_In(dataRFOut1_In), .dataRFOut2_In(dataRFOut2_In), .address_In(address_In),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWriteData(memWriteData),
        .memAck(memAck), .memReadData_In(memReadData_In),
        .instruction(instruction), .dataRFOut1(dataRFOut1), .dataRFOut2(dataRFOut2),
        .aluRESULTout(aluRESULTout), .memoryReadData(memoryReadData), .address(address),
        .out_valid(out_valid)
    );

    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit isStore(input logic [3:0] op);
        return op == 4'hC;
    endfunction

    function automatic bit isLoad(input logic [3:0] op);
        return (op == 4'hD) || (op == 4'hF);
    endfunction

    task automatic modelReset();
        busy = 1'b0; expValid = 1'b0;
        expInstr = BUBBLE; expAlu = 20'h0; expRf1 = 20'h0; expRf2 = 20'h0;
        expMrd = 20'h0; expAddr = 4'h0; expMemAddr = 8'h0; expMemWd = 20'h0;
        bInstr = 20'h0; bAlu = 20'h0; bRf1 = 20'h0; bRf2 = 20'h0; bAddr = 4'h0;
    endtask

    task automatic checkAll(input string phase);
        checkValue({phase, ".out_valid"}, out_valid, expValid);
        checkValue({phase, ".instruction"}, instruction, expValid ? expInstr : BUBBLE);
        checkValue({phase, ".aluRESULTout"}, aluRESULTout, expAlu);
        checkValue({phase, ".dataRFOut1"}, dataRFOut1, expRf1);
        checkValue({phase, ".dataRFOut2"}, dataRFOut2, expRf2);
        checkValue({phase, ".address"}, address, expAddr);
        checkValue({phase, ".memoryReadData"}, memoryReadData, expMrd);
        checkValue({phase, ".memReq"}, memReq, busy);
        checkValue({phase, ".memWe"}, memWe, busy && isStore(bInstr[19:16]));
        checkValue({phase, ".memAddr"}, memAddr, expMemAddr);
        checkValue({phase, ".memWriteData"}, memWriteData, expMemWd);
    endtask

    // Called shortly after a rising edge; pulses reset with no clock edge inside
    task automatic doReset();
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll("reset");
        checkValue("reset.in_ready", in_ready, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkValue("release.in_ready", in_ready, 1'b1);
    endtask

    // One clock cycle: apply inputs, predict, clock, compare
    task automatic step(input logic v, input logic [19:0] ins, input logic [19:0] alu,
                        input logic [19:0] rf1, input logic [19:0] rf2, input logic [3:0] ad,
                        input logic ack, input logic [19:0] rd);
        bit completes;
        in_valid = v; instruction_In = ins; aluResult_In = alu;
        dataRFOut1_In = rf1; dataRFOut2_In = rf2; address_In = ad;
        memAck = ack; memReadData_In = rd;
        #1;
        checkValue("in_ready", in_ready, !busy);
        expValid = 1'b0;
        if (busy) begin
`ifdef MEM_WAIT_STATE_EN
            completes = ack;
`else
            completes = 1'b1;
`endif
            if (completes) begin
                expValid = 1'b1;
                expInstr = bInstr; expAlu = bAlu; expRf1 = bRf1; expRf2 = bRf2; expAddr = bAddr;
                expMrd = isLoad(bInstr[19:16]) ? rd : 20'h0;
                busy = 1'b0;
            end
        end else if (v) begin
            if (isStore(ins[19:16]) || isLoad(ins[19:16])) begin
                busy = 1'b1;
                bInstr = ins; bAlu = alu; bRf1 = rf1; bRf2 = rf2; bAddr = ad;
                expMemAddr = alu[7:0];
                expMemWd = rf2;
            end else begin
                expValid = 1'b1;
                expInstr = ins; expAlu = alu; expRf1 = rf1; expRf2 = rf2; expAddr = ad;
                expMrd = 20'h0;
            end
        end
        @(posedge clock);
        #1;
        checkAll("cycle");
    endtask

    task automatic idle(input logic ack, input logic [19:0] rd);
        step(1'b0, 20'h00000, 20'h0, 20'h0, 20'h0, 4'h0, ack, rd);
    endtask

    initial begin
        logic [3:0]  op;
        logic [19:0] ins;
        reset = 1'b1;
        in_valid = 1'b0; instruction_In = 20'h0; aluResult_In = 20'h0;
        dataRFOut1_In = 20'h0; dataRFOut2_In = 20'h0; address_In = 4'h0;
        memAck = 1'b0; memReadData_In = 20'h0;
        modelReset();
        @(posedge clock);
        #1;
        doReset();

        // Back-to-back ALU ops
        step(1'b1, 20'h1ABCD, 20'h00012, 20'h11111, 20'h22222, 4'h3, 1'b0, 20'h0);
        step(1'b1, 20'h10123, 20'h00034, 20'h33333, 20'h44444, 4'h5, 1'b0, 20'h0);

        // Load with a stalled memory, then a store
        step(1'b1, 20'hD0007, 20'h00025, 20'h00001, 20'h00002, 4'h7, 1'b0, 20'h0);
        idle(1'b0, 20'hABCDE);
        idle(1'b0, 20'hABCDE);
        idle(1'b1, 20'hABCDE);
        idle(1'b0, 20'h0);
        step(1'b1, 20'hC0009, 20'h00010, 20'h00005, 20'h12345, 4'h2, 1'b0, 20'h0);
        idle(1'b0, 20'h55555);
        idle(1'b1, 20'h55555);
        idle(1'b0, 20'h0);

        // Reset while a load is waiting, then a normal op
        step(1'b1, 20'hF0001, 20'h000AA, 20'h0, 20'h0, 4'h1, 1'b0, 20'h0);
        doReset();
        idle(1'b1, 20'h77777);
        step(1'b1, 20'h20042, 20'h00099, 20'h00001, 20'h00002, 4'h9, 1'b0, 20'h0);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0: op = 4'hC;
                    1: op = 4'hD;
                    default: op = 4'hF;
                endcase
            end else begin
                op = 4'($urandom_range(0, 15));
            end
            ins = {op, 16'($urandom)};
            step($urandom_range(0, 3) != 0, ins, 20'($urandom), 20'($urandom), 20'($urandom),
                 4'($urandom), $urandom_range(0, 2) == 0, 20'($urandom));
            if ($urandom_range(0, 79) == 0) doReset();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports in_valid  in  1 and in_ready  out  1  upstream (execute) handshake; transfer when both high at a clock edge.
REQ-004 SHALL have ports instruction_In  in  20, aluResult_In  in  20, dataRFOut1_In  in  20, dataRFOut2_In  in  20, address_In  in  4  execute-stage results; opcode = instruction_In[19:16].
REQ-005 SHALL have ports memReq  out  1, memWe  out  1, memAddr  out  8, memWriteData  out  20, memAck  in  1, memReadData_In  in  20  data-memory port.
REQ-006 SHALL have ports instruction, dataRFOut1, dataRFOut2, aluRESULTout, memoryReadData  out  20 each, address  out  4, out_valid  out  1  registered MEM/WB outputs feeding the write-back stage.

Function
REQ-007 SHALL classify opcode 4'b1100 as store, 4'b1101 and 4'b1111 as load, all others as non-memory.
REQ-008 SHALL implement FSM states IDLE and WAIT; in_ready SHALL equal (state == IDLE) and not be driven high during reset.
REQ-009 IDLE, transfer of non-memory op: SHALL load all MEM/WB outputs from inputs next edge, memoryReadData = 0, out_valid = 1 for one cycle; state stays IDLE (latency 1, throughput 1/cycle).
REQ-010 IDLE, transfer of load/store: SHALL latch inputs internally and go to WAIT; memReq = 1 from the next cycle.
REQ-011 In WAIT SHALL hold memReq = 1, memWe = 1 for store else 0, memAddr = latched aluResult[7:0], memWriteData = latched dataRFOut2, all stable until completion.
REQ-012 WAIT completion: SHALL load MEM/WB outputs from latched values, memoryReadData = memReadData_In for load, 0 for store; out_valid = 1 for one cycle; memReq drops; return to IDLE.
REQ-013 When out_valid = 0, instruction output SHALL read 20'hC0000 (bubble, suppresses write-back); other outputs hold last values.
REQ-014 in_valid while in_ready = 0 SHALL be ignored (upstream holds); memAck in IDLE SHALL be ignored.
REQ-015 memReq, memWe SHALL be 0 whenever state = IDLE.
REQ-016 Memory-op latency in_valid-accept to out_valid SHALL be 1 + number of WAIT cycles.

Reset
REQ-017 Reset SHALL asynchronously force state = IDLE, memReq = 0, memWe = 0, memAddr = 0, memWriteData = 0, out_valid = 0, instruction = 20'hC0000, all other outputs 0.
REQ-018 Reset asserted in WAIT SHALL abort the access immediately; no out_valid for the aborted instruction after release.
REQ-019 First transfer SHALL be possible at the first rising edge after reset deasserts.

Configuration
REQ-020 With MEM_WAIT_STATE_EN defined, WAIT SHALL complete only on an edge where memAck = 1 (unbounded stall).
REQ-021 Without MEM_WAIT_STATE_EN, memAck SHALL be ignored and WAIT SHALL last exactly one cycle, sampling memReadData_In at that edge (fixed single-cycle memory).

Verification
REQ-022 Reset pulse mid-cycle with no clock -> all outputs at REQ-017 values immediately; in_ready = 1 after release.
REQ-023 Back-to-back ADD-class ops (opcode 0001, aluResult 0x00012 then 0x00034) -> out_valid high two consecutive cycles, aluRESULTout 0x00012 then 0x00034, in_ready never low.
REQ-024 Load opcode 1101, aluResult 0x00025, memAck after 3 WAIT cycles, memReadData_In 0xABCDE (MEM_WAIT_STATE_EN) -> memReq high 3 cycles with memAddr 0x25, memWe 0, then memoryReadData 0xABCDE, out_valid 1 for one cycle.
REQ-025 Store opcode 1100, aluResult 0x00010, dataRFOut2 0x12345 -> memWe 1, memAddr 0x10, memWriteData 0x12345 until ack; output instruction opcode 1100, memoryReadData 0.
REQ-026 Reset asserted during WAIT of a load -> memReq drops same cycle; no out_valid after release; next op accepted normally.
REQ-027 Build without MEM_WAIT_STATE_EN, load with memAck tied 0 -> memReq exactly one cycle, out_valid next cycle with sampled memReadData_In.
